// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtraction controller.
//   state_t    : controller state encoding (IDLE/RUN/DONE)
//   cnt_width  : bit-counter width for a given operand width (minimum 1 bit)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // $clog2(1) is 0, so a single-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fs.sv
// 1-bit full subtractor: computes a - b - cin.
// Ports:
//   a, b, cin : minuend bit, subtrahend bit, borrow-in
//   D         : difference bit
//   B         : borrow-out (set when a < b + cin)
module fs (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic D,
  output logic B
);

  assign D = a ^ b ^ cin;
  assign B = (~a & (b | cin)) | (b & cin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one fs cell, fed LSB first, one bit per clock.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start_valid/ready  : operand handshake (ready only in IDLE)
//   a_in, b_in, bin    : minuend, subtrahend, borrow-in
//   diff_out, bout     : registered difference and final borrow
//   out_valid/ready    : result handshake (valid only in DONE)
//   busy               : operation in progress or result pending
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] diff_nxt;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             b_bit;
  logic             last;

  fs u_fs (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (brw),
    .D   (d_bit),
    .B   (b_bit)
  );

  // Difference bits enter at the MSB and walk down; after WIDTH shifts the
  // first-computed (LSB) bit lands in position 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_nxt = d_bit;
    end else begin : g_wn
      assign diff_nxt = {d_bit, diff_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last        = (cnt == LAST);
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign out_valid   = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_sh  <= '0;
      brw      <= 1'b0;
      cnt      <= '0;
      diff_out <= '0;
      bout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            brw     <= bin;
            cnt     <= '0;
            diff_sh <= '0;
          end
        end
        RUN: begin
          diff_sh <= diff_nxt;
          brw     <= b_bit;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          // Counter stops at the terminal count so it never wraps.
          if (last) begin
            diff_out <= diff_nxt;
            bout     <= b_bit;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  // WIDTH=8 instance
  logic       sv8 = 1'b0, bin8 = 1'b0, ordy8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       sr8, bo8, ov8, busy8;
  logic [7:0] d8;

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8),
    .a_in(a8), .b_in(b8), .bin(bin8), .diff_out(d8), .bout(bo8),
    .out_valid(ov8), .out_ready(ordy8), .busy(busy8)
  );

  // WIDTH=4 instance
  logic       sv4 = 1'b0, bin4 = 1'b0, ordy4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0;
  logic       sr4, bo4, ov4, busy4;
  logic [3:0] d4;

  serial_sub_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4),
    .a_in(a4), .b_in(b4), .bin(bin4), .diff_out(d4), .bout(bo4),
    .out_valid(ov4), .out_ready(ordy4), .busy(busy4)
  );

  // WIDTH=1 instance
  logic sv1 = 1'b0, bin1 = 1'b0, ordy1 = 1'b1;
  logic a1 = 1'b0, b1 = 1'b0;
  logic sr1, bo1, ov1, busy1, d1;

  serial_sub_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1),
    .a_in(a1), .b_in(b1), .bin(bin1), .diff_out(d1), .bout(bo1),
    .out_valid(ov1), .out_ready(ordy1), .busy(busy1)
  );

  typedef struct {
    logic [31:0] d;
    logic        bo;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   last_acc = -1;
  bit   rnd_rdy  = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: plain integer subtraction, result taken mod 2^w, borrow = negative.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic bi, input int acc);
    exp_t        e;
    longint      r;
    longint      m;
    r     = longint'(a) - longint'(b) - (bi ? 64'sd1 : 64'sd0);
    m     = (64'sd1 <<< w) - 1;
    e.d   = 32'(r & m);
    e.bo  = (r < 0);
    e.acc = acc;
    return e;
  endfunction

  // Monitor: compares every cycle a result is presented (stalls included),
  // pops on the handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (ov8) begin
        if (sbq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL w8_unexpected: got out_valid=1 expected no pending result");
        end else begin
          if (!prev_ov) chk("w8_latency", 32'(cyc - sbq[0].acc), 32'd8);
          chk("w8_diff", {24'd0, d8}, sbq[0].d);
          chk("w8_bout", {31'd0, bo8}, {31'd0, sbq[0].bo});
          if (ordy8) void'(sbq.pop_front());
        end
      end
      prev_ov = ov8;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd_rdy) ordy8 = 1'($urandom_range(0, 1));
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi, input bit keep);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; sv8 = 1'b1;
    while (!sr8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sr8) begin
      chk("w8_accept_timeout", 32'd0, 32'd1);
      sv8 = 1'b0;
    end else begin
      e = model(8, {24'd0, a}, {24'd0, b}, bi, cyc + 1);
      sbq.push_back(e);
      if (keep && last_acc >= 0) chk("w8_interval", 32'(cyc + 1 - last_acc), 32'd10);
      last_acc = cyc + 1;
      @(negedge clk);
      if (!keep) sv8 = 1'b0;
    end
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("w8_drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    int   n;
    exp_t e;

    repeat (3) @(negedge clk);
    chk("rst_sr8",   {31'd0, sr8},   32'd1);
    chk("rst_ov8",   {31'd0, ov8},   32'd0);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_d8",    {24'd0, d8},    32'd0);
    chk("rst_bo8",   {31'd0, bo8},   32'd0);
    chk("rst_sr4",   {31'd0, sr4},   32'd1);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk("rst_sr1",   {31'd0, sr1},   32'd1);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    rst = 1'b0;

    // Directed cases
    issue8(8'h35, 8'h12, 1'b0, 1'b0);
    chk("run_busy8", {31'd0, busy8}, 32'd1);
    chk("run_sr8",   {31'd0, sr8},   32'd0);
    drain8();
    issue8(8'h12, 8'h35, 1'b0, 1'b0);
    drain8();
    issue8(8'h00, 8'h00, 1'b1, 1'b0);
    drain8();

    // Backpressure with start pulses during RUN/DONE
    @(posedge clk); #1 ordy8 = 1'b0;
    issue8(8'h80, 8'h01, 1'b0, 1'b0);
    sv8 = 1'b1;
    n = 0;
    while (!ov8 && n < 50) begin
      chk("bp_sr_run", {31'd0, sr8}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk("bp_ov_seen", {31'd0, ov8}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ov_held", {31'd0, ov8}, 32'd1);
      chk("bp_sr_done", {31'd0, sr8}, 32'd0);
    end
    sv8 = 1'b0;
    @(posedge clk); #1 ordy8 = 1'b1;
    drain8();

    // Reset during the third RUN cycle
    issue8(8'h55, 8'h22, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_sr8",   {31'd0, sr8},   32'd1);
    chk("mr_ov8",   {31'd0, ov8},   32'd0);
    chk("mr_busy8", {31'd0, busy8}, 32'd0);
    chk("mr_d8",    {24'd0, d8},    32'd0);
    issue8(8'h0A, 8'h03, 1'b0, 1'b0);
    drain8();

    // Back-to-back with start_valid held high
    last_acc = -1;
    repeat (6) issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    sv8 = 1'b0;
    drain8();

    // Random operands with random consumer readiness
    rnd_rdy = 1'b1;
    repeat (25) issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    @(posedge clk);
    #2 rnd_rdy = 1'b0;
    ordy8 = 1'b1;
    drain8();

    // WIDTH=4 exhaustive
    for (int unsigned a = 0; a < 16; a++) begin
      for (int unsigned b = 0; b < 16; b++) begin
        for (int unsigned bi = 0; bi < 2; bi++) begin
          @(negedge clk);
          a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bi); sv4 = 1'b1;
          n = 0;
          while (!sr4 && n < 50) begin @(negedge clk); n++; end
          @(negedge clk);
          sv4 = 1'b0;
          n = 0;
          while (!ov4 && n < 50) begin @(negedge clk); n++; end
          e = model(4, a, b, 1'(bi), 0);
          chk("w4_ov",   {31'd0, ov4}, 32'd1);
          chk("w4_diff", {28'd0, d4},  e.d);
          chk("w4_bout", {31'd0, bo4}, {31'd0, e.bo});
        end
      end
    end

    // WIDTH=1 truth table
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      a1 = k[2]; b1 = k[1]; bin1 = k[0]; sv1 = 1'b1;
      n = 0;
      while (!sr1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      sv1 = 1'b0;
      chk("w1_run_busy", {31'd0, busy1}, 32'd1);
      n = 0;
      while (!ov1 && n < 50) begin @(negedge clk); n++; end
      chk("w1_run_len", 32'(n), 32'd1);
      e = model(1, {31'd0, k[2]}, {31'd0, k[1]}, k[0], 0);
      chk("w1_ov",   {31'd0, ov1}, 32'd1);
      chk("w1_diff", {31'd0, d1},  e.d);
      chk("w1_bout", {31'd0, bo1}, {31'd0, e.bo});
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
